// File: rtl/apb4_csr_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : apb4_csr_bridge
//  Purpose  : APB4 slave to CSR cpuif bridge with stall handling, bounded wait,
//             response timeout, misalignment rejection and error counting.
//  Revision : 1.0
// ============================================================================
module apb4_csr_bridge #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERRCNT_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_apb_psel,
  input  logic                    s_apb_penable,
  input  logic                    s_apb_pwrite,
  input  logic [ADDR_WIDTH-1:0]   s_apb_paddr,
  input  logic [DATA_WIDTH-1:0]   s_apb_pwdata,
  input  logic [DATA_WIDTH/8-1:0] s_apb_pstrb,
  input  logic [2:0]              s_apb_pprot,
  output logic                    s_apb_pready,
  output logic [DATA_WIDTH-1:0]   s_apb_prdata,
  output logic                    s_apb_pslverr,
  output logic                    cpuif_req,
  output logic                    cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0]   cpuif_addr,
  output logic [DATA_WIDTH-1:0]   cpuif_wr_data,
  output logic [DATA_WIDTH-1:0]   cpuif_wr_biten,
  input  logic                    cpuif_req_stall_wr,
  input  logic                    cpuif_req_stall_rd,
  input  logic                    cpuif_rd_ack,
  input  logic                    cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0]   cpuif_rd_data,
  input  logic                    cpuif_wr_ack,
  input  logic                    cpuif_wr_err,
  output logic [ERRCNT_WIDTH-1:0] err_count
);

  localparam int c_STRB_W = DATA_WIDTH / 8;
  localparam int c_LSB_W  = $clog2(c_STRB_W);
  localparam int c_CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_TMO = c_CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                   r_state;
  logic                     r_is_wr;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [c_STRB_W-1:0]      r_strb;
  logic [c_CNT_W-1:0]       r_cnt;
  logic                     r_pready;
  logic                     r_pslverr;
  logic [DATA_WIDTH-1:0]    r_prdata;
  logic [ERRCNT_WIDTH-1:0]  r_err_count;

  logic                     w_misaligned;
  logic                     w_stall;
  logic                     w_ack;
  logic                     w_ack_err;
  logic                     w_req;
  logic                     w_timeout;
  logic [DATA_WIDTH-1:0]    w_biten;
  logic                     w_unused_pprot;

  assign w_unused_pprot = ^s_apb_pprot;

  generate
    if (c_LSB_W == 0) begin : g_align_none
      assign w_misaligned = 1'b0;
    end else begin : g_align_chk
      assign w_misaligned = |s_apb_paddr[c_LSB_W-1:0];
    end
  endgenerate

  generate
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_biten
      assign w_biten[i] = r_strb[i/8];
    end
  endgenerate

  // Only the handshake signals of the latched direction are considered.
  assign w_stall   = r_is_wr ? cpuif_req_stall_wr : cpuif_req_stall_rd;
  assign w_ack     = r_is_wr ? cpuif_wr_ack       : cpuif_rd_ack;
  assign w_ack_err = r_is_wr ? cpuif_wr_err       : cpuif_rd_err;
  assign w_req     = (r_state == S_REQ) && !w_stall;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_TMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_is_wr     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_cnt       <= '0;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_prdata    <= '0;
      r_err_count <= '0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        S_IDLE: begin
          if (s_apb_psel && !s_apb_penable) begin
            r_is_wr <= s_apb_pwrite;
            r_addr  <= s_apb_paddr;
            r_wdata <= s_apb_pwdata;
            r_strb  <= s_apb_pwrite ? s_apb_pstrb : '0;
            if (w_misaligned) begin
              r_state   <= S_RESP;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (w_req) begin
            r_cnt <= '0;
            if (w_ack) begin
              r_state   <= S_RESP;
              r_pready  <= 1'b1;
              r_pslverr <= w_ack_err;
              r_prdata  <= r_is_wr ? '0 : cpuif_rd_data;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_ack) begin
            r_state   <= S_RESP;
            r_pready  <= 1'b1;
            r_pslverr <= w_ack_err;
            r_prdata  <= r_is_wr ? '0 : cpuif_rd_data;
          end else if (w_timeout) begin
            r_state   <= S_RESP;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (r_pslverr && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERRCNT_WIDTH'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_apb_pready    = r_pready;
  assign s_apb_pslverr   = r_pslverr;
  assign s_apb_prdata    = r_prdata;
  assign cpuif_req       = w_req;
  assign cpuif_req_is_wr = r_is_wr;
  assign cpuif_addr      = r_addr;
  assign cpuif_wr_data   = r_wdata;
  assign cpuif_wr_biten  = w_biten;
  assign err_count       = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_apb4_csr_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb4_csr_bridge
//  Purpose  : Directed scoreboard bench for apb4_csr_bridge.
//  Revision : 1.0
// ============================================================================
module tb_apb4_csr_bridge;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        req, req_is_wr;
  logic [2:0]  caddr;
  logic [31:0] wr_data, wr_biten;
  logic        stall_wr = 1'b0, stall_rd = 1'b0;
  logic        rd_ack = 1'b0, rd_err = 1'b0, wr_ack = 1'b0, wr_err = 1'b0;
  logic [31:0] rd_data = '0;
  logic [7:0]  err_count;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] exp_errcnt = 8'h00;

  always #5 clk = ~clk;

  apb4_csr_bridge #(
    .ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO), .ERRCNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
    .s_apb_paddr(paddr), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
    .s_apb_pprot(3'b000),
    .s_apb_pready(pready), .s_apb_prdata(prdata), .s_apb_pslverr(pslverr),
    .cpuif_req(req), .cpuif_req_is_wr(req_is_wr), .cpuif_addr(caddr),
    .cpuif_wr_data(wr_data), .cpuif_wr_biten(wr_biten),
    .cpuif_req_stall_wr(stall_wr), .cpuif_req_stall_rd(stall_rd),
    .cpuif_rd_ack(rd_ack), .cpuif_rd_err(rd_err), .cpuif_rd_data(rd_data),
    .cpuif_wr_ack(wr_ack), .cpuif_wr_err(wr_err),
    .err_count(err_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_pready"}, 64'(pready), 64'd0);
    check({tag, "_pslverr"}, 64'(pslverr), 64'd0);
    check({tag, "_prdata"}, 64'(prdata), 64'd0);
    check({tag, "_req"}, 64'(req), 64'd0);
  endtask

  task automatic clear_csr();
    stall_wr = 1'b0; stall_rd = 1'b0;
    rd_ack = 1'b0; wr_ack = 1'b0; rd_err = 1'b0; wr_err = 1'b0;
    rd_data = '0;
  endtask

  // ack_dly: cycles after the accepted request the CSR acks (0 = same cycle),
  // negative = never acks. wrong_ack pulses the opposite-direction ack meanwhile.
  task automatic xfer(input string tag, input logic wr, input logic [2:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input int stall_n, input int ack_dly, input logic [31:0] csr_rdata,
                      input logic csr_err, input logic wrong_ack);
    logic        misal, tmo, exp_err, ack;
    logic [31:0] exp_rdata, exp_biten;
    int          req_cyc, exp_resp, n_req, resp_cyc;
    rsp_t        got, want;
    misal     = (addr[1:0] != 2'b00);
    tmo       = !misal && (ack_dly < 0);
    exp_err   = misal || tmo || csr_err;
    exp_rdata = (wr || misal || tmo) ? 32'h0 : csr_rdata;
    for (int b = 0; b < 32; b++) exp_biten[b] = wr ? strb[b/8] : 1'b0;
    req_cyc  = stall_n + 1;
    exp_resp = misal ? 1 : req_cyc + ack_dly + 1;

    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    sb.push_back('{err: exp_err, data: exp_rdata});
    n_req = 0; resp_cyc = -1;
    for (int c = 1; c <= 60 && resp_cyc < 0; c++) begin
      @(negedge clk);
      penable  = 1'b1;
      stall_wr = wr && (c <= stall_n);
      stall_rd = !wr && (c <= stall_n);
      ack      = !misal && (ack_dly >= 0) && (c == req_cyc + ack_dly);
      wr_ack   = wr ? ack : (wrong_ack && !ack);
      rd_ack   = wr ? (wrong_ack && !ack) : ack;
      wr_err   = ack ? csr_err : 1'b1;
      rd_err   = ack ? csr_err : 1'b1;
      rd_data  = ack ? csr_rdata : 32'hBAD0_BAD0;
      #1;
      if (req) begin
        n_req++;
        if (n_req == 1) begin
          check({tag, "_req_cycle"}, 64'(c), 64'(req_cyc));
          check({tag, "_req_is_wr"}, 64'(req_is_wr), 64'(wr));
          check({tag, "_addr"}, 64'(caddr), 64'(addr));
          check({tag, "_biten"}, 64'(wr_biten), 64'(exp_biten));
          if (wr) check({tag, "_wr_data"}, 64'(wr_data), 64'(wdata));
        end
      end
      if (pready) begin
        resp_cyc = c;
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          want = sb.pop_front();
          got  = '{err: pslverr, data: prdata};
          check({tag, "_pslverr"}, 64'(got.err), 64'(want.err));
          check({tag, "_prdata"}, 64'(got.data), 64'(want.data));
        end
      end
    end
    if (resp_cyc < 0) begin
      check({tag, "_pready_timeout"}, 64'd0, 64'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (tmo) begin
      check({tag, "_resp_window"},
            64'((resp_cyc >= req_cyc + 1 + TMO) && (resp_cyc <= req_cyc + 2 + TMO)), 64'd1);
    end else begin
      check({tag, "_resp_cycle"}, 64'(resp_cyc), 64'(exp_resp));
    end
    check({tag, "_req_pulses"}, 64'(n_req), misal ? 64'd0 : 64'd1);

    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    clear_csr();
    #1;
    idle_outputs({tag, "_after"});
    if (exp_err && exp_errcnt != 8'hFF) exp_errcnt++;
    check({tag, "_err_count"}, 64'(err_count), 64'(exp_errcnt));
  endtask

  initial begin
    #2;
    idle_outputs("reset");
    check("reset_err_count", 64'(err_count), 64'd0);
    check("reset_addr", 64'(caddr), 64'd0);
    check("reset_biten", 64'(wr_biten), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    xfer("t1_wr_comb_ack", 1'b1, 3'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0);
    xfer("t2_rd_wait3", 1'b0, 3'h4, 32'h0, 4'h0, 0, 3, 32'h1234_5678, 1'b0, 1'b1);
    xfer("wr_strb0_stall", 1'b1, 3'h0, 32'hCAFE_F00D, 4'h0, 2, 1, 32'h0, 1'b0, 1'b1);
    xfer("wr_csr_err", 1'b1, 3'h4, 32'h0BAD_CAFE, 4'h5, 0, 2, 32'h0, 1'b1, 1'b0);
    xfer("t3_rd_stall4", 1'b0, 3'h0, 32'h0, 4'hF, 4, 1, 32'hA5A5_5A5A, 1'b0, 1'b0);
    xfer("t4_rd_timeout", 1'b0, 3'h4, 32'h0, 4'h0, 0, -1, 32'h0, 1'b0, 1'b0);

    // Late acks while idle must be ignored.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rd_ack = 1'b1; wr_ack = 1'b1; rd_data = 32'h7777_7777;
      #1;
      idle_outputs("late_ack");
    end
    @(negedge clk);
    clear_csr();
    check("late_ack_sb_empty", 64'(sb.size()), 64'd0);

    xfer("t5_misaligned", 1'b1, 3'h2, 32'h1111_1111, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 255; k++) begin
      xfer("t5_sat", k[0], 3'h1 + 3'(k % 3), 32'h0, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0);
    end
    check("t5_saturated", 64'(err_count), 64'hFF);

    // Reset asserted while the bridge waits on a silent CSR.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'h4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      penable = 1'b1;
    end
    #2;
    rst = 1'b1;
    #1;
    idle_outputs("t6_rst");
    check("t6_rst_err_count", 64'(err_count), 64'd0);
    check("t6_rst_is_wr", 64'(req_is_wr), 64'd0);
    check("t6_rst_addr", 64'(caddr), 64'd0);
    exp_errcnt = 8'h00;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      idle_outputs("t6_no_pready");
    end
    xfer("t6_after_rst", 1'b0, 3'h4, 32'h0, 4'h0, 0, 0, 32'hFEED_0001, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
